piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer_if.sv | 25 ++
 rtl/piso_serializer.sv | 84 ++++++++
 tb/tb_piso_serializer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Parallel-load / serial-out handshake bundle shared by the producer, the
// serial consumer and the piso_serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             direction;
  logic             shift_en;
  logic             serial_out;
  logic             serial_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, data_in, direction, shift_en,
    input  load_ready, serial_out, serial_valid, busy, done
  );

  modport slave (
    input  load_valid, data_in, direction, shift_en,
    output load_ready, serial_out, serial_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: accepts a WIDTH-bit word, emits it one bit
// per consumed cycle (MSB or LSB first), pulses done after the last bit.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  piso_serializer_if.slave   bus
);
  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             load_ready;
  logic             load;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    last_bit   = (state_q == SHIFT) && bus.shift_en && (cnt_q == LAST);
    load_ready = (state_q == IDLE) || last_bit;
    load       = bus.load_valid && load_ready;

    case (state_q)
      IDLE: begin
        // shift_en has no meaning without a frame, so nothing moves here
      end
      SHIFT: begin
        if (bus.shift_en) begin
          shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_d   = cnt_q + CW'(1);
        end
        if (last_bit) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load can only happen from IDLE or on the last-bit cycle, which lets
    // the next frame follow with no idle gap.
    if (load) begin
      shreg_d = bus.data_in;
      dir_d   = bus.direction;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.serial_valid = (state_q == SHIFT);
  assign bus.busy         = (state_q == SHIFT);
  assign bus.serial_out   = (state_q == SHIFT) && (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]);
  // Masked so a pending pulse never shows while reset is held low
  assign bus.done         = done_q && reset;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed and randomized checks of piso_serializer against a bit-index
// reference model and a behavioural serial-in receiver.
module tb_piso_serializer;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  piso_serializer_if #(.WIDTH(WIDTH)) bus ();

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int               n_assert = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] sipo;
  logic             sipo_dir;
  logic [WIDTH-1:0] seq, w, nw, rv;
  logic             d, nd, b2b, pd;

  function automatic logic exp_bit(input logic [WIDTH-1:0] word, input logic dr, input int i);
    return dr ? word[i] : word[WIDTH-1-i];
  endfunction

  function automatic logic [WIDTH-1:0] exp_seq(input logic [WIDTH-1:0] word, input logic dr);
    logic [WIDTH-1:0] s = '0;
    for (int i = 0; i < WIDTH; i++) s = {s[WIDTH-2:0], exp_bit(word, dr, i)};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    #1;
    chk({tag, ".serial_valid"}, 32'(bus.serial_valid), 32'd0);
    chk({tag, ".busy"},         32'(bus.busy),         32'd0);
    chk({tag, ".serial_out"},   32'(bus.serial_out),   32'd0);
    chk({tag, ".load_ready"},   32'(bus.load_ready),   32'd1);
  endtask

  task automatic do_load(input logic [WIDTH-1:0] word, input logic dr);
    bus.load_valid = 1'b1;
    bus.data_in    = word;
    bus.direction  = dr;
    bus.shift_en   = 1'($urandom_range(0, 1));
    #1;
    chk("load.load_ready", 32'(bus.load_ready), 32'd1);
    chk("load.busy",       32'(bus.busy),       32'd0);
    sipo_dir = dr;
    tick();
    bus.load_valid = 1'b0;
  endtask

  // Runs one frame from its first visible bit to the done cycle (no tick after).
  // stall_at >= 0: hold shift_en low stall_len cycles after stall_at bits;
  // stall_at == -2: random stalls.
  task automatic frame(input logic [WIDTH-1:0] word, input logic dr,
                       input int stall_at, input int stall_len, input logic prev_done,
                       input logic nxt, input logic [WIDTH-1:0] nword, input logic ndir,
                       output logic [WIDTH-1:0] obs_seq);
    int               consumed = 0;
    int               stalled  = 0;
    int               cyc      = 0;
    logic             se, last;
    logic [WIDTH-1:0] s = '0;
    while (consumed < WIDTH) begin
      if (stall_at == -2) se = ($urandom_range(0, 3) != 0);
      else                se = !(consumed == stall_at && stalled < stall_len);
      if (!se) stalled++;
      last           = se && (consumed == WIDTH - 1);
      bus.shift_en   = se;
      bus.load_valid = last ? nxt : 1'($urandom_range(0, 1));
      bus.data_in    = (last && nxt) ? nword : WIDTH'($urandom);
      bus.direction  = (last && nxt) ? ndir : 1'($urandom_range(0, 1));
      #1;
      chk("frame.serial_valid", 32'(bus.serial_valid), 32'd1);
      chk("frame.busy",         32'(bus.busy),         32'd1);
      chk("frame.serial_out",   32'(bus.serial_out),   32'(exp_bit(word, dr, consumed)));
      chk("frame.load_ready",   32'(bus.load_ready),   32'(last));
      chk("frame.done",         32'(bus.done),         32'(cyc == 0 && prev_done));
      if (se && bus.serial_valid) begin
        sipo = sipo_dir ? {bus.serial_out, sipo[WIDTH-1:1]} : {sipo[WIDTH-2:0], bus.serial_out};
        s    = {s[WIDTH-2:0], bus.serial_out};
      end
      if (se) consumed++;
      cyc++;
      tick();
    end
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'($urandom_range(0, 1));
    #1;
    chk("end.done",         32'(bus.done),         32'd1);
    chk("end.sipo_word",    32'(sipo),             32'(word));
    chk("end.serial_valid", 32'(bus.serial_valid), 32'(nxt));
    chk("end.busy",         32'(bus.busy),         32'(nxt));
    chk("end.load_ready",   32'(bus.load_ready),   32'(!nxt));
    if (nxt) sipo_dir = ndir;
    obs_seq = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    bus.load_valid = 1'b1;
    bus.data_in    = 8'hAA;
    bus.direction  = 1'b0;
    bus.shift_en   = 1'b1;
    sipo           = '0;
    sipo_dir       = 1'b0;
    tick();
    tick();
    chk("rst.done", 32'(bus.done), 32'd0);
    check_idle("rst");

    reset          = 1'b1;
    bus.load_valid = 1'b0;
    tick();
    tick();
    check_idle("idle_shift_en");
    chk("idle.done", 32'(bus.done), 32'd0);

    do_load(8'hC1, 1'b0);
    frame(8'hC1, 1'b0, -1, 0, 1'b0, 1'b0, '0, 1'b0, seq);
    chk("msb_first.seq", 32'(seq), 32'h0000_00C1);
    tick();
    check_idle("after_msb");
    chk("after_msb.done", 32'(bus.done), 32'd0);

    do_load(8'hC1, 1'b1);
    frame(8'hC1, 1'b1, -1, 0, 1'b0, 1'b0, '0, 1'b0, seq);
    chk("lsb_first.seq", 32'(seq), 32'h0000_0083);
    tick();

    do_load(8'hC1, 1'b0);
    frame(8'hC1, 1'b0, 2, 3, 1'b0, 1'b0, '0, 1'b0, seq);
    chk("stall.seq", 32'(seq), 32'h0000_00C1);
    tick();

    do_load(8'hC1, 1'b0);
    frame(8'hC1, 1'b0, -1, 0, 1'b0, 1'b1, 8'h5A, 1'b0, seq);
    chk("b2b1.seq", 32'(seq), 32'h0000_00C1);
    frame(8'h5A, 1'b0, -1, 0, 1'b1, 1'b0, '0, 1'b0, seq);
    chk("b2b2.seq", 32'(seq), 32'h0000_005A);
    tick();

    do_load(8'h96, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.shift_en = 1'b1;
      #1;
      chk("pre_rst.serial_out", 32'(bus.serial_out), 32'(exp_bit(8'h96, 1'b0, i)));
      tick();
    end
    reset          = 1'b0;
    bus.load_valid = 1'b1;
    bus.data_in    = 8'h3C;
    tick();
    chk("mid_rst.done", 32'(bus.done), 32'd0);
    reset          = 1'b1;
    bus.load_valid = 1'b0;
    check_idle("mid_rst");
    tick();
    chk("post_rst.done", 32'(bus.done), 32'd0);
    check_idle("post_rst");

    do_load(8'hFF, 1'b1);
    frame(8'hFF, 1'b1, -1, 0, 1'b0, 1'b0, '0, 1'b0, seq);
    chk("all_ones.seq", 32'(seq), 32'h0000_00FF);
    tick();

    w  = WIDTH'($urandom);
    d  = 1'($urandom_range(0, 1));
    pd = 1'b0;
    do_load(w, d);
    for (int k = 0; k < 40; k++) begin
      b2b = (k < 39) && ($urandom_range(0, 1) == 1);
      nw  = WIDTH'($urandom);
      nd  = 1'($urandom_range(0, 1));
      frame(w, d, -2, 0, pd, b2b, nw, nd, seq);
      rv = exp_seq(w, d);
      chk("rand.seq", 32'(seq), 32'(rv));
      if (!b2b && k < 39) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        do_load(nw, nd);
      end
      w  = nw;
      d  = nd;
      pd = b2b;
    end
    tick();
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
